// File: rtl/pwl_share_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwl_share_arb : round-robin time-sharing of one pwl evaluator            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pwl_share_arb #(
    parameter int N_REQ         = 4,
    parameter int IN_WIDTH      = 16,
    parameter int SETTING_WIDTH = 4,
    parameter int OUT_WIDTH     = 18,
    parameter int PWL_LAT       = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 req_valid,
    output logic [N_REQ-1:0]                 req_ready,
    input  logic [N_REQ*IN_WIDTH-1:0]        req_in,
    input  logic [N_REQ*SETTING_WIDTH-1:0]   req_setting,
    output logic [IN_WIDTH-1:0]              pwl_in,
    output logic [SETTING_WIDTH-1:0]         pwl_setting,
    input  logic [OUT_WIDTH-1:0]             pwl_out,
    output logic [N_REQ-1:0]                 rsp_valid,
    output logic [N_REQ*OUT_WIDTH-1:0]       rsp_data,
    output logic [$clog2(PWL_LAT+2)-1:0]     inflight
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int INF_W = $clog2(PWL_LAT+2);
    localparam logic [INF_W-1:0] INF_MAX = INF_W'(PWL_LAT+1);

    logic [IN_WIDTH-1:0]        pwl_in_q;
    logic [SETTING_WIDTH-1:0]   pwl_setting_q;
    logic [N_REQ-1:0]           rsp_valid_q;
    logic [N_REQ*OUT_WIDTH-1:0] rsp_data_q;
    logic [INF_W-1:0]           inflight_q, inflight_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    // Stage 0 lines up with pwl_in; stage PWL_LAT lines up with pwl_out.
    logic                       tag_v_q   [0:PWL_LAT];
    logic [IDX_W-1:0]           tag_idx_q [0:PWL_LAT];

    logic [N_REQ-1:0]           w_grant;
    logic [IDX_W-1:0]           w_grant_idx;
    logic                       w_found;
    logic                       w_transfer;
    logic                       w_return;
    logic [IDX_W-1:0]           w_ret_idx;
    logic [IDX_W:0]             w_sum;
    logic [IDX_W-1:0]           w_cand;

    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
        if (w_found && rst) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_transfer = |w_grant;
    assign w_return   = tag_v_q[PWL_LAT];
    assign w_ret_idx  = tag_idx_q[PWL_LAT];

    always_comb begin
        ptr_d = ptr_q;
        if (w_transfer) begin
            ptr_d = (w_grant_idx == IDX_W'(N_REQ-1)) ? '0 : w_grant_idx + IDX_W'(1);
        end
        inflight_d = inflight_q + INF_W'(w_transfer) - INF_W'(w_return);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pwl_in_q      <= '0;
            pwl_setting_q <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            inflight_q    <= '0;
            ptr_q         <= '0;
            for (int s = 0; s <= PWL_LAT; s++) begin
                tag_v_q[s]   <= 1'b0;
                tag_idx_q[s] <= '0;
            end
        end else begin
            if (w_transfer) begin
                pwl_in_q      <= req_in[w_grant_idx*IN_WIDTH +: IN_WIDTH];
                pwl_setting_q <= req_setting[w_grant_idx*SETTING_WIDTH +: SETTING_WIDTH];
            end
            tag_v_q[0]   <= w_transfer;
            tag_idx_q[0] <= w_grant_idx;
            for (int s = 1; s <= PWL_LAT; s++) begin
                tag_v_q[s]   <= tag_v_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
            rsp_valid_q <= '0;
            if (w_return) begin
                rsp_valid_q[w_ret_idx]                       <= 1'b1;
                rsp_data_q[w_ret_idx*OUT_WIDTH +: OUT_WIDTH] <= pwl_out;
            end
            inflight_q <= inflight_d;
            ptr_q      <= ptr_d;
        end
    end

    assign req_ready   = w_grant;
    assign pwl_in      = pwl_in_q;
    assign pwl_setting = pwl_setting_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign inflight    = inflight_q;

`ifndef SYNTHESIS
    a_inflight_max: assert property (@(posedge clk) disable iff (!rst) inflight_q <= INF_MAX);
`endif

endmodule
`default_nettype wire
